// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase scheduler for a two-road intersection with a pedestrian crossing.
// Sequences NS/EW signal heads and walk from vehicle sensors and a latched pedestrian request.
module traffic_phase_scheduler #(
    parameter int unsigned GREEN_MIN   = 4,
    parameter int unsigned GREEN_MAX   = 8,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned WALK_TIME   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_NS,
    input  logic       car_EW,
    input  logic       ped_req,
    output logic [1:0] light_NS,
    output logic [1:0] light_EW,
    output logic       walk,
    output logic [2:0] phase
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    localparam int unsigned MAX_P = max2(max2(max2(GREEN_MIN, GREEN_MAX), max2(YELLOW_TIME, ALLRED_TIME)), WALK_TIME);
    localparam int unsigned TW    = $clog2(MAX_P) + 1;

    typedef logic [TW-1:0] tmr_t;

    localparam tmr_t GMIN_END   = tmr_t'(GREEN_MIN - 1);
    localparam tmr_t GMAX_END   = tmr_t'(GREEN_MAX - 1);
    localparam tmr_t YELLOW_END = tmr_t'(YELLOW_TIME - 1);
    localparam tmr_t ALLRED_END = tmr_t'(ALLRED_TIME - 1);
    localparam tmr_t WALK_END   = tmr_t'(WALK_TIME - 1);

    localparam logic [2:0] ST_ALL_RED   = 3'd0;
    localparam logic [2:0] ST_NS_GREEN  = 3'd1;
    localparam logic [2:0] ST_NS_YELLOW = 3'd2;
    localparam logic [2:0] ST_EW_GREEN  = 3'd3;
    localparam logic [2:0] ST_EW_YELLOW = 3'd4;
    localparam logic [2:0] ST_PED_WALK  = 3'd5;

    localparam logic LG_NS = 1'b0;
    localparam logic LG_EW = 1'b1;

    logic [2:0] state_q, state_d;
    tmr_t       timer_q, timer_d;
    logic       ped_pending_q, ped_pending_d;
    logic       last_green_q, last_green_d;
    logic       from_walk_q, from_walk_d;
    logic       state_change_s;
    logic       is_green_s;

    // State register and phase bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ALL_RED;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
            last_green_q  <= LG_EW;
            from_walk_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            last_green_q  <= last_green_d;
            from_walk_q   <= from_walk_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = ST_ALL_RED;
        case (state_q)
            ST_ALL_RED: begin
                if (timer_q == ALLRED_END) begin
                    if (ped_pending_q && !from_walk_q) begin
                        state_d = ST_PED_WALK;
                    end else if (last_green_q == LG_NS) begin
                        state_d = ST_EW_GREEN;
                    end else begin
                        state_d = ST_NS_GREEN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_NS_GREEN: begin
                if ((timer_q >= GMIN_END) && (car_EW || ped_pending_q) &&
                    (!car_NS || (timer_q == GMAX_END))) begin
                    state_d = ST_NS_YELLOW;
                end else begin
                    state_d = state_q;
                end
            end
            ST_EW_GREEN: begin
                if ((timer_q >= GMIN_END) && (car_NS || ped_pending_q) &&
                    (!car_EW || (timer_q == GMAX_END))) begin
                    state_d = ST_EW_YELLOW;
                end else begin
                    state_d = state_q;
                end
            end
            ST_NS_YELLOW, ST_EW_YELLOW: begin
                if (timer_q == YELLOW_END) begin
                    state_d = ST_ALL_RED;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PED_WALK: begin
                if (timer_q == WALK_END) begin
                    state_d = ST_ALL_RED;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
            end
        endcase
    end

    // Timer, pedestrian latch and history flags follow the chosen next state
    always_comb begin
        state_change_s = (state_d != state_q);
        is_green_s     = (state_q == ST_NS_GREEN) || (state_q == ST_EW_GREEN);

        // Green may rest indefinitely, so its timer parks at the max-green mark
        if (state_change_s) begin
            timer_d = '0;
        end else if (is_green_s && (timer_q == GMAX_END)) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + tmr_t'(1);
        end

        if (state_change_s && (state_d == ST_PED_WALK)) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && (state_q != ST_PED_WALK)) begin
            ped_pending_d = 1'b1;
        end else begin
            ped_pending_d = ped_pending_q;
        end

        if (state_d == ST_NS_GREEN) begin
            last_green_d = LG_NS;
        end else if (state_d == ST_EW_GREEN) begin
            last_green_d = LG_EW;
        end else begin
            last_green_d = last_green_q;
        end

        if (state_change_s) begin
            from_walk_d = (state_q == ST_PED_WALK);
        end else begin
            from_walk_d = from_walk_q;
        end
    end

    // Output decode from the state register
    always_comb begin
        light_NS = 2'b00;
        light_EW = 2'b00;
        walk     = 1'b0;
        phase    = state_q;
        case (state_q)
            ST_NS_GREEN: begin
                light_NS = 2'b10;
            end
            ST_NS_YELLOW: begin
                light_NS = 2'b01;
            end
            ST_EW_GREEN: begin
                light_EW = 2'b10;
            end
            ST_EW_YELLOW: begin
                light_EW = 2'b01;
            end
            ST_PED_WALK: begin
                walk = 1'b1;
            end
            default: begin
                walk = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops and compares each cycle.
module tb_traffic_phase_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YEL  = 2;
    localparam int ARED = 1;
    localparam int WLK  = 3;

    logic       clk;
    logic       reset;
    logic       car_NS;
    logic       car_EW;
    logic       ped_req;
    logic [1:0] light_NS;
    logic [1:0] light_EW;
    logic       walk;
    logic [2:0] phase;

    int checks = 0;
    int fails  = 0;

    logic [7:0] exp_q[$];

    // reference model: phase id, cycles shown in this phase (1 on entry), pedestrian latch, history
    int m_phase = 0;
    int m_age   = 1;
    bit m_pend  = 1'b0;
    bit m_last_ew = 1'b1;
    bit m_from_walk = 1'b0;

    traffic_phase_scheduler #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YEL),
        .ALLRED_TIME(ARED), .WALK_TIME(WLK)
    ) dut (
        .clk(clk), .reset(reset), .car_NS(car_NS), .car_EW(car_EW), .ped_req(ped_req),
        .light_NS(light_NS), .light_EW(light_EW), .walk(walk), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] lights_of(input int p);
        case (p)
            1:       return 5'b10_00_0;
            2:       return 5'b01_00_0;
            3:       return 5'b00_10_0;
            4:       return 5'b00_01_0;
            5:       return 5'b00_00_1;
            default: return 5'b00_00_0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit cns, input bit cew, input bit ped);
        int  nxt;
        bit  own;
        bit  other;
        if (r) begin
            m_phase = 0; m_age = 1; m_pend = 1'b0; m_last_ew = 1'b1; m_from_walk = 1'b0;
            return;
        end
        nxt = m_phase;
        case (m_phase)
            0: if (m_age >= ARED) nxt = (m_pend && !m_from_walk) ? 5 : (m_last_ew ? 1 : 3);
            1, 3: begin
                own   = (m_phase == 1) ? cns : cew;
                other = (m_phase == 1) ? cew : cns;
                if (m_age >= GMIN && (other || m_pend) && (!own || m_age >= GMAX)) nxt = m_phase + 1;
            end
            2, 4: if (m_age >= YEL) nxt = 0;
            5:    if (m_age >= WLK) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 5 && m_phase != 5) m_pend = 1'b0;
        else if (ped && m_phase != 5) m_pend = 1'b1;
        if (nxt != m_phase) begin
            m_from_walk = (m_phase == 5);
            m_age = 1;
            if (nxt == 1) m_last_ew = 1'b0;
            if (nxt == 3) m_last_ew = 1'b1;
        end else begin
            m_age++;
        end
        m_phase = nxt;
    endtask

    task automatic step(input bit r, input bit cns, input bit cew, input bit ped);
        reset = r; car_NS = cns; car_EW = cew; ped_req = ped;
        model_step(r, cns, cew, ped);
        exp_q.push_back({3'(m_phase), lights_of(m_phase)});
        @(negedge clk);
    endtask

    // Monitor: compare each post-edge output against the queued expectation and check invariants
    initial begin
        logic [7:0] exp;
        bit had_green = 0, saw_y = 0, saw_r = 0, prev_green = 0;
        bit had_walk = 0, green_since_walk = 0, prev_walk = 0;
        bit is_green;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if ({phase, light_NS, light_EW, walk} !== exp) begin
                    fails++;
                    $display("FAIL outputs t=%0t got phase=%0d ns=%b ew=%b walk=%b expected phase=%0d ns=%b ew=%b walk=%b",
                             $time, phase, light_NS, light_EW, walk, exp[7:5], exp[4:3], exp[2:1], exp[0]);
                end
                checks++;
                if (light_NS != 2'b00 && light_EW != 2'b00) begin
                    fails++;
                    $display("FAIL both_nonred t=%0t got ns=%b ew=%b expected one of them 00", $time, light_NS, light_EW);
                end
                checks++;
                if (walk && (light_NS != 2'b00 || light_EW != 2'b00)) begin
                    fails++;
                    $display("FAIL walk_lights t=%0t got ns=%b ew=%b with walk=1 expected 00/00", $time, light_NS, light_EW);
                end
                if (reset) begin
                    had_green = 0; saw_y = 0; saw_r = 0; prev_green = 0;
                    had_walk = 0; green_since_walk = 0; prev_walk = 0;
                end else begin
                    is_green = (light_NS == 2'b10) || (light_EW == 2'b10);
                    if (is_green && !prev_green && had_green) begin
                        checks++;
                        if (!(saw_y && saw_r)) begin
                            fails++;
                            $display("FAIL green_path t=%0t got yellow=%0b allred=%0b expected both 1", $time, saw_y, saw_r);
                        end
                    end
                    if (is_green) begin
                        had_green = 1; saw_y = 0; saw_r = 0; green_since_walk = 1;
                    end else begin
                        if (light_NS == 2'b01 || light_EW == 2'b01) saw_y = 1;
                        if (light_NS == 2'b00 && light_EW == 2'b00 && !walk) saw_r = 1;
                    end
                    if (walk && !prev_walk) begin
                        if (had_walk) begin
                            checks++;
                            if (!green_since_walk) begin
                                fails++;
                                $display("FAIL walk_repeat t=%0t got back-to-back walk expected vehicle green between", $time);
                            end
                        end
                        had_walk = 1; green_since_walk = 0;
                    end
                    prev_green = is_green;
                    prev_walk  = walk;
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        bit cns, cew, pd, rs;
        reset = 1'b1; car_NS = 1'b0; car_EW = 1'b0; ped_req = 1'b0;

        step(1, 0, 0, 0); step(1, 0, 0, 0);
        repeat (21) step(0, 0, 0, 0);

        step(1, 0, 0, 0); step(1, 0, 0, 0);
        repeat (30) step(0, 0, 1, 0);

        step(1, 0, 0, 0); step(1, 0, 0, 0);
        repeat (30) step(0, 1, 1, 0);

        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 1);
        repeat (20) step(0, 0, 0, 0);

        step(1, 0, 0, 0); step(1, 0, 0, 0);
        repeat (60) step(0, 0, 0, 1);

        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 20 && m_phase != 2; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0);

        cns = 0; cew = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7, 0) == 0) cns = ~cns;
            if ($urandom_range(7, 0) == 0) cew = ~cew;
            pd = ($urandom_range(15, 0) == 0);
            rs = ($urandom_range(299, 0) == 0);
            step(rs, cns, cew, pd);
        end

        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expectations expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Demand-driven phase scheduler for a two-road intersection with a pedestrian crossing. It sequences the NS and EW signal heads from vehicle sensors and a latched pedestrian request, and enforces minimum green, maximum green, yellow, all-red clearance and walk intervals. It replaces the fixed-cycle sequencer and keeps the same light encoding, so existing light drivers and monitors attach unchanged.

Parameters:
GREEN_MIN, 4, minimum green cycles per vehicle phase (>=1)
GREEN_MAX, 8, green cycles after which the phase ends if competing demand exists (>=GREEN_MIN)
YELLOW_TIME, 2, yellow cycles (>=1)
ALLRED_TIME, 1, all-red clearance cycles (>=1)
WALK_TIME, 3, pedestrian walk cycles (>=1)

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
car_NS  input  1  level; vehicle present on the NS approach
car_EW  input  1  level; vehicle present on the EW approach
ped_req  input  1  pedestrian button; pulse or level
light_NS  output  2  00 red, 10 green, 01 yellow
light_EW  output  2  same encoding as light_NS
walk  output  1  1 only during the pedestrian phase
phase  output  3  current state code, for debug and bench observation

Behaviour:
- States and codes: ALL_RED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, PED_WALK=5. Codes 6 and 7 are illegal and go to ALL_RED on the next edge.
- Output decode from the state register:
  - NS_GREEN: light_NS=10, light_EW=00
  - NS_YELLOW: light_NS=01, light_EW=00
  - EW_GREEN: light_NS=00, light_EW=10
  - EW_YELLOW: light_NS=00, light_EW=01
  - ALL_RED and PED_WALK: both 00
  - walk=1 only in PED_WALK
- Registered state only: outputs change only on clock edges.
- Reset (any cycle, including mid-phase): on the next edge state=ALL_RED, timer=0, ped_pending=0, last_green=EW. Outputs become 00/00, walk=0, phase=0. Reset dominates all other inputs.
- Timer:
  - Cleared on every state change; otherwise increments each cycle.
  - Saturates at GREEN_MAX-1 in green states.
  - Width is $clog2 of the largest parameter, plus 1.
  - A state of duration N occupies exactly N cycles.
- ped_pending:
  - Set on any edge where ped_req=1 and the state is not PED_WALK.
  - Cleared on the edge that enters PED_WALK. That clear wins over a simultaneous ped_req.
  - ped_req during PED_WALK is ignored.
- ALL_RED: when timer==ALLRED_TIME-1, the next state is:
  - PED_WALK if ped_pending=1 and the previous state was not PED_WALK;
  - otherwise the opposite of last_green (NS_GREEN if last_green=EW, else EW_GREEN).
- NS_GREEN: sets last_green=NS on entry.
  - Competing demand = car_EW OR ped_pending.
  - Go to NS_YELLOW when timer>=GREEN_MIN-1 AND competing demand AND (car_NS=0 OR timer==GREEN_MAX-1).
  - With no competing demand, rest in green indefinitely.
- EW_GREEN: symmetric, with car_NS as the opposite sensor; sets last_green=EW on entry.
- Yellow states: go to ALL_RED when timer==YELLOW_TIME-1.
- PED_WALK: go to ALL_RED when timer==WALK_TIME-1. The following ALL_RED then goes to the vehicle phase opposite last_green.
- First edge after reset release, with the default ALLRED_TIME=1: NS_GREEN.
- Safety invariants, checked every cycle:
  - never both lights non-red;
  - walk=1 implies both lights 00;
  - every green-to-green path passes through yellow and ALL_RED.

Test Plan:
- Reset held 2 cycles, car_*=0, ped_req=0 -> 00/00, walk=0 during reset; NS=10 on the first edge after release; NS stays 10 for 20 further cycles (rest in green).
- car_EW=1 from release, car_NS=0 -> NS=10 for 4 cycles, NS=01 for 2, 00/00 for 1, EW=10; EW then rests green for 20 cycles.
- car_NS=1 and car_EW=1 constant -> NS green 8 cycles (GREEN_MAX), yellow 2, all-red 1, EW green 8, yellow 2, all-red 1, NS green again.
- One-cycle ped_req pulse on the 2nd NS green cycle, no cars -> NS green until 4 cycles total, yellow 2, all-red 1, walk=1 for 3 cycles with both lights 00, all-red 1, then EW=10.
- ped_req held high continuously, no cars -> exactly one walk phase per ALL_RED pass; never two walk phases back-to-back without an intervening vehicle green.
- Reset asserted on the 1st NS_YELLOW cycle with ped_pending=1 -> 00/00 and phase=0 on the next edge; after release NS=10 with no walk phase (pending cleared).
